// File: rtl/logic_axi4_stream_mux_buffer_if.sv
// -----------------------------------------------------------------------------
// logic_axi4_stream_if
//   AXI4-Stream bundle used between the mux tree and its output skid buffer.
//
//   Signals : tvalid, tready, tdata, tkeep, tstrb, tlast, tuser, tdest, tid
//   Modports:
//     rx - consumer side: samples the beat, drives tready
//     tx - producer side: drives the beat, samples tready
// -----------------------------------------------------------------------------
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;

    modport rx (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        output tready
    );

    modport tx (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        input  tready
    );
endinterface

// File: rtl/logic_axi4_stream_mux_buffer.sv
// -----------------------------------------------------------------------------
// logic_axi4_stream_mux_buffer
//   Two-entry registered skid buffer at the output of the AXI4-Stream mux tree.
//   Registers the forward path (tvalid + payload) and the backward path
//   (tready) so neither crosses this block combinationally, while still
//   sustaining one beat per cycle. Beats pass unmodified and in order.
//
//   Ports:
//     aclk     - clock, all state on rising edge
//     areset_n - asynchronous active-low reset
//     rx       - upstream stream (mux tree output), rx modport
//     tx       - downstream stream, tx modport
// -----------------------------------------------------------------------------
module logic_axi4_stream_mux_buffer #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter bit USE_TLAST   = 1'b1,
    parameter bit USE_TKEEP   = 1'b1,
    parameter bit USE_TSTRB   = 1'b1
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    logic_axi4_stream_if.rx        rx,
    logic_axi4_stream_if.tx        tx
);

    // Packed payload layout; disabled sideband fields take zero bits.
    localparam int DATA_W    = TDATA_BYTES * 8;
    localparam int KEEP_W    = USE_TKEEP ? TDATA_BYTES : 0;
    localparam int STRB_W    = USE_TSTRB ? TDATA_BYTES : 0;
    localparam int LAST_W    = USE_TLAST ? 1 : 0;
    localparam int KEEP_LSB  = DATA_W;
    localparam int STRB_LSB  = KEEP_LSB + KEEP_W;
    localparam int LAST_LSB  = STRB_LSB + STRB_W;
    localparam int USER_LSB  = LAST_LSB + LAST_W;
    localparam int DEST_LSB  = USER_LSB + TUSER_WIDTH;
    localparam int ID_LSB    = DEST_LSB + TDEST_WIDTH;
    localparam int PAYLOAD_W = ID_LSB + TID_WIDTH;

    // Encoding is {main_valid, skid_valid}; 2'b01 never occurs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic                   tready_q, tready_d;
    logic [PAYLOAD_W-1:0]   rx_word;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   main_valid;
    logic                   rx_fire;
    logic                   tx_fire;

    // ------------------------------------------------------------------
    // Payload packing / unpacking
    // ------------------------------------------------------------------
    assign rx_word[0 +: DATA_W]             = rx.tdata;
    assign rx_word[USER_LSB +: TUSER_WIDTH] = rx.tuser;
    assign rx_word[DEST_LSB +: TDEST_WIDTH] = rx.tdest;
    assign rx_word[ID_LSB +: TID_WIDTH]     = rx.tid;

    assign tx.tdata = main_q[0 +: DATA_W];
    assign tx.tuser = main_q[USER_LSB +: TUSER_WIDTH];
    assign tx.tdest = main_q[DEST_LSB +: TDEST_WIDTH];
    assign tx.tid   = main_q[ID_LSB +: TID_WIDTH];

    generate
        if (USE_TKEEP) begin : g_keep
            assign rx_word[KEEP_LSB +: TDATA_BYTES] = rx.tkeep;
            assign tx.tkeep = main_q[KEEP_LSB +: TDATA_BYTES];
        end else begin : g_no_keep
            assign tx.tkeep = '1;
        end

        if (USE_TSTRB) begin : g_strb
            assign rx_word[STRB_LSB +: TDATA_BYTES] = rx.tstrb;
            assign tx.tstrb = main_q[STRB_LSB +: TDATA_BYTES];
        end else begin : g_no_strb
            assign tx.tstrb = '1;
        end

        if (USE_TLAST) begin : g_last
            assign rx_word[LAST_LSB] = rx.tlast;
            assign tx.tlast = main_q[LAST_LSB];
        end else begin : g_no_last
            assign tx.tlast = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshakes; both ready and valid come straight from flops.
    // ------------------------------------------------------------------
    assign main_valid = state_q[1];
    assign tx.tvalid  = main_valid;
    assign rx.tready  = tready_q;
    assign rx_fire    = rx.tvalid & tready_q;
    assign tx_fire    = main_valid & tx.tready;

    // ------------------------------------------------------------------
    // Next-state / datapath select
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (rx_fire) begin
                    main_d  = rx_word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (rx_fire && tx_fire) begin
                    main_d = rx_word;           // pass-through, stay ONE
                end else if (rx_fire) begin
                    skid_d  = rx_word;          // consumer stalled: park beat
                    state_d = FULL;
                end else if (tx_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // tready_q is 0 here, so only the drain side can move.
                if (tx_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Ready is registered from the next state, never from tx.tready.
        tready_d = (state_d != FULL);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= EMPTY;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
        end
    end

    // NOTE: payload registers are deliberately left without reset; their
    // contents are only observed while the matching valid flop is set.
    always_ff @(posedge aclk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule
